// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared FSM encodings and slice width for the nibble-serial adder.
package nibble_serial_add_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_add_nibble.sv
// 4-bit combinational ripple-carry slice; also exports the carry out of bit 2
// so the top can form signed overflow on the most significant nibble.
module add_nibble
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             c2,
  output logic             co
);

  logic c;

  always_comb begin
    s  = '0;
    c2 = 1'b0;
    c  = ci;
    for (int i = 0; i < NIB_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      if (i == NIB_W - 2) c2 = c;
    end
    co = c;
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/sub using one reused 4-bit slice, LSB nibble first; done pulses
// NIBBLES+1 cycles after accept. start is ignored (not queued) while busy.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     op_sub,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                     ci,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                     co,
  output logic                     ovf
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  state_t            state_q, state_d;
  logic [W-1:0]      a_q, b_q, sum_q;
  logic              carry_q, co_q, ovf_q;
  logic [IW-1:0]     idx_q;
  logic [NIB_W-1:0]  sl_a, sl_b, sl_s;
  logic              sl_c2, sl_co;
  logic              last;

  assign sl_a = a_q[NIB_W*idx_q +: NIB_W];
  assign sl_b = b_q[NIB_W*idx_q +: NIB_W];
  assign last = (idx_q == IW'(NIBBLES - 1));

  add_nibble u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry_q),
    .s  (sl_s),
    .c2 (sl_c2),
    .co (sl_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Subtraction is folded in at accept: b is stored inverted and carry seeded to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          a_q     <= a;
          b_q     <= op_sub ? ~b : b;
          carry_q <= op_sub | ci;
          idx_q   <= '0;
          sum_q   <= '0;
        end
        ST_RUN: begin
          sum_q[NIB_W*idx_q +: NIB_W] <= sl_s;
          carry_q <= sl_co;
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            co_q  <= sl_co;
            ovf_q <= sl_c2 ^ sl_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum = sum_q;
  assign co  = co_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomised and directed checks of the nibble-serial adder against a plain
// arithmetic reference model.
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst, start, op_sub, ci;
  logic [W-1:0] a, b;
  logic         busy, done, co, ovf;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .ci     (ci),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .co     (co),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and check result, latency and done pulse.
  // With inject set, start is held high with fresh operands from mid-RUN
  // through DONE; none of it may be accepted.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic oci, input logic osub, input bit inject);
    int           cyc;
    logic [W:0]   full;
    logic [W-1:0] bb, exp_sum;
    logic         exp_co, exp_ovf;

    bb      = osub ? ~ob : ob;
    full    = {1'b0, oa} + {1'b0, bb} + (W+1)'(osub ? 1'b1 : oci);
    exp_sum = full[W-1:0];
    exp_co  = full[W];
    exp_ovf = (oa[W-1] == bb[W-1]) && (exp_sum[W-1] != oa[W-1]);

    a = oa; b = ob; ci = oci; op_sub = osub; start = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
    check("busy_run", 32'(busy), 32'd1);
    while (!done && cyc < 20) begin
      if (inject && cyc == 2) begin
        a = W'($urandom); b = W'($urandom); ci = ~oci; op_sub = ~osub; start = 1'b1;
      end
      step();
      cyc++;
    end
    check("latency", 32'(cyc), 32'(NIBBLES + 1));
    check("done_busy", 32'(busy), 32'd1);
    check("sum", 32'(sum), 32'(exp_sum));
    check("co", 32'(co), 32'(exp_co));
    check("ovf", 32'(ovf), 32'(exp_ovf));
    step();
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
    check("sum_hold", 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; ci = 1'b0; a = '0; b = '0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_co", 32'(co), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    step();

    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);

    // Reset mid-RUN while the third nibble is being processed.
    a = 16'h1234; b = 16'h1111; ci = 1'b0; op_sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_co", 32'(co), 32'd0);
    run_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 1'b0);

    // start coincident with reset must be dropped, not remembered.
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("rststart_busy", 32'(busy), 32'd0);
    step();
    check("rststart_dropped", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), bit'(i % 5 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
